// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM state encoding,
// requester ids and default widths.
package ram_arb_pkg;

    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_READ_LAT = 1;

    // Port 0 is the cache refill/write-back path, port 1 the auxiliary master.
    localparam logic PORT_CACHE = 1'b0;
    localparam logic PORT_AUX   = 1'b1;

    // Encoding is shown on the 7-segment display; 4..7 are unused.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3
    } state_t;

    // The port that did not win the previous grant.
    function automatic logic other_port(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic. Purely combinational; the "last"
// pointer is owned by the parent so it only moves when a transaction ends.
module rr_arbiter2
    import ram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt_valid,
    output logic gnt_id
);

    // A lone requester always wins; on contention the port that was not served last wins.
    always_comb begin
        gnt_valid = req0 | req1;
        gnt_id    = PORT_CACHE;
        if (req0 && req1) begin
            gnt_id = other_port(last);
        end else if (req1) begin
            gnt_id = PORT_AUX;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester controller for a single-port synchronous RAM.
// Handshake: a requester raises reqN with stable weN/addrN/wdataN and keeps
// them until doneN pulses for one cycle; it drops reqN on the edge that ends
// the done cycle. A req still high in the following IDLE cycle starts a new
// transaction. Operands are latched at grant, so later input changes are
// ignored until the FSM is back in IDLE.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int READ_LAT = DEF_READ_LAT   // legal range 1..7
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              done0,
    output logic [DATA_W-1:0] rdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata1,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,

    output logic              busy,
    output logic              owner,
    output logic [2:0]        state
);

    // Final wait count: ram_q is valid on this cycle of WAIT.
    localparam logic [2:0] WAIT_LAST = 3'(READ_LAT - 1);

    state_t              state_q;
    logic                last_q;
    logic                owner_q;
    logic                we_q;
    logic [2:0]          wait_cnt_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [DATA_W-1:0]   ram_data_q;
    logic                ram_wren_q;
    logic                done0_q;
    logic                done1_q;
    logic [DATA_W-1:0]   rdata0_q;
    logic [DATA_W-1:0]   rdata1_q;

    logic                gnt_valid;
    logic                gnt_id;
    logic                we_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;

    rr_arbiter2 u_rr (
        .req0      (req0),
        .req1      (req1),
        .last      (last_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Operands of whichever port the arbiter is granting this cycle.
    always_comb begin
        we_d    = we0;
        addr_d  = addr0;
        wdata_d = wdata0;
        if (gnt_id == PORT_AUX) begin
            we_d    = we1;
            addr_d  = addr1;
            wdata_d = wdata1;
        end
    end

    // Transaction FSM with registered RAM strobes, done pulses and read data.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            last_q     <= PORT_AUX;
            owner_q    <= PORT_AUX;
            we_q       <= 1'b0;
            wait_cnt_q <= 3'd0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_wren_q <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            ram_wren_q <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        owner_q    <= gnt_id;
                        we_q       <= we_d;
                        ram_addr_q <= addr_d;
                        ram_data_q <= wdata_d;
                        ram_wren_q <= we_d;
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt_q <= 3'd0;
                    if (we_q) begin
                        done0_q <= (owner_q == PORT_CACHE);
                        done1_q <= (owner_q == PORT_AUX);
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        if (owner_q == PORT_CACHE) begin
                            rdata0_q <= ram_q;
                        end else begin
                            rdata1_q <= ram_q;
                        end
                        done0_q <= (owner_q == PORT_CACHE);
                        done1_q <= (owner_q == PORT_AUX);
                        state_q <= ST_DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 3'd1;
                    end
                end
                ST_DONE: begin
                    last_q  <= owner_q;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign done0    = done0_q;
    assign done1    = done1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign ram_addr = ram_addr_q;
    assign ram_data = ram_data_q;
    assign ram_wren = ram_wren_q;
    assign busy     = (state_q != ST_IDLE);
    assign owner    = owner_q;
    assign state    = state_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: instance 0 uses READ_LAT=1, instance 1
// uses READ_LAT=3. Each instance talks to its own behavioural RAM.
module tb_ram_port_arbiter;

    logic       clock = 1'b0;
    logic       reset;

    logic [1:0] req0_v, we0_v, req1_v, we1_v;
    logic [1:0] done0_v, done1_v, wren_v, busy_v, owner_v;
    logic [4:0] addr0_v [2];
    logic [4:0] addr1_v [2];
    logic [4:0] ram_addr_v [2];
    logic [7:0] wdata0_v [2];
    logic [7:0] wdata1_v [2];
    logic [7:0] rdata0_v [2];
    logic [7:0] rdata1_v [2];
    logic [7:0] ram_data_v [2];
    logic [2:0] state_v [2];
    logic [7:0] ram_q_a, ram_q_b;

    logic [7:0] ram_a [32];
    logic [7:0] ram_b [32];
    logic [7:0] pipe_b0, pipe_b1;

    logic [7:0] mem_model [2][32];
    logic [7:0] exp_q [$];
    int         exp_port_q [$];
    int         model_last [2];
    int         checks = 0;
    int         errors = 0;

    always #5 clock = ~clock;

    ram_port_arbiter #(.ADDR_W(5), .DATA_W(8), .READ_LAT(1)) dut_a (
        .clock (clock), .reset (reset),
        .req0 (req0_v[0]), .we0 (we0_v[0]), .addr0 (addr0_v[0]), .wdata0 (wdata0_v[0]),
        .done0 (done0_v[0]), .rdata0 (rdata0_v[0]),
        .req1 (req1_v[0]), .we1 (we1_v[0]), .addr1 (addr1_v[0]), .wdata1 (wdata1_v[0]),
        .done1 (done1_v[0]), .rdata1 (rdata1_v[0]),
        .ram_addr (ram_addr_v[0]), .ram_data (ram_data_v[0]), .ram_wren (wren_v[0]),
        .ram_q (ram_q_a), .busy (busy_v[0]), .owner (owner_v[0]), .state (state_v[0])
    );

    ram_port_arbiter #(.ADDR_W(5), .DATA_W(8), .READ_LAT(3)) dut_b (
        .clock (clock), .reset (reset),
        .req0 (req0_v[1]), .we0 (we0_v[1]), .addr0 (addr0_v[1]), .wdata0 (wdata0_v[1]),
        .done0 (done0_v[1]), .rdata0 (rdata0_v[1]),
        .req1 (req1_v[1]), .we1 (we1_v[1]), .addr1 (addr1_v[1]), .wdata1 (wdata1_v[1]),
        .done1 (done1_v[1]), .rdata1 (rdata1_v[1]),
        .ram_addr (ram_addr_v[1]), .ram_data (ram_data_v[1]), .ram_wren (wren_v[1]),
        .ram_q (ram_q_b), .busy (busy_v[1]), .owner (owner_v[1]), .state (state_v[1])
    );

    // Single-port RAM, one cycle from address register to q.
    always @(posedge clock) begin
        if (wren_v[0]) ram_a[ram_addr_v[0]] <= ram_data_v[0];
        ram_q_a <= ram_a[ram_addr_v[0]];
    end

    // Single-port RAM, three cycles from address register to q.
    always @(posedge clock) begin
        if (wren_v[1]) ram_b[ram_addr_v[1]] <= ram_data_v[1];
        pipe_b0 <= ram_b[ram_addr_v[1]];
        pipe_b1 <= pipe_b0;
        ram_q_b <= pipe_b1;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int inst, input int port, input logic req, input logic we,
                            input logic [4:0] addr, input logic [7:0] wdata);
        if (port == 0) begin
            req0_v[inst] = req; we0_v[inst] = we; addr0_v[inst] = addr; wdata0_v[inst] = wdata;
        end else begin
            req1_v[inst] = req; we1_v[inst] = we; addr1_v[inst] = addr; wdata1_v[inst] = wdata;
        end
    endtask

    task automatic drop_req(input int inst, input int port);
        if (port == 0) req0_v[inst] = 1'b0;
        else           req1_v[inst] = 1'b0;
    endtask

    function automatic logic get_done(input int inst, input int port);
        return (port == 0) ? done0_v[inst] : done1_v[inst];
    endfunction

    function automatic logic [7:0] get_rdata(input int inst, input int port);
        return (port == 0) ? rdata0_v[inst] : rdata1_v[inst];
    endfunction

    task automatic check_idle(input int inst, input string tag);
        chk({tag, "_state"}, 32'(state_v[inst]), 32'd0);
        chk({tag, "_busy"}, 32'(busy_v[inst]), 32'd0);
    endtask

    // One complete transaction: drive, wait for done (bounded), check timing and data.
    task automatic run_txn(input int inst, input int port, input logic we,
                           input logic [4:0] addr, input logic [7:0] wdata, input int lat);
        int         cyc;
        int         wren_cnt;
        logic       seen;
        logic [7:0] exp_rd;
        set_port(inst, port, 1'b1, we, addr, wdata);
        if (we) mem_model[inst][addr] = wdata;
        else    exp_q.push_back(mem_model[inst][addr]);
        cyc = 0; wren_cnt = 0; seen = 1'b0;
        while (!seen && cyc < 20) begin
            step();
            cyc++;
            if (wren_v[inst]) wren_cnt++;
            if (cyc == 1) begin
                chk("wren_at_issue", 32'(wren_v[inst]), 32'(we));
                chk("state_issue", 32'(state_v[inst]), 32'd1);
                if (we) chk("ram_data", 32'(ram_data_v[inst]), 32'(wdata));
            end
            chk("ram_addr_hold", 32'(ram_addr_v[inst]), 32'(addr));
            chk("other_done_low", 32'(get_done(inst, 1 - port)), 32'd0);
            seen = get_done(inst, port);
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(cyc), we ? 32'd2 : 32'(2 + lat));
        chk("wren_cycles", 32'(wren_cnt), we ? 32'd1 : 32'd0);
        chk("owner", 32'(owner_v[inst]), 32'(port));
        if (!we && exp_q.size() > 0) begin
            exp_rd = exp_q.pop_front();
            chk("rdata", 32'(get_rdata(inst, port)), 32'(exp_rd));
        end
        model_last[inst] = port;
        drop_req(inst, port);
        step();
        chk("done_one_cycle", 32'(get_done(inst, port)), 32'd0);
        check_idle(inst, "post_txn");
    endtask

    initial begin
        int         n;
        int         cyc;
        int         got;
        int         exp_p;
        logic [4:0] ra;
        logic [7:0] rd;
        int         rp;

        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_port(i, 0, 1'b0, 1'b0, 5'd0, 8'd0);
            set_port(i, 1, 1'b0, 1'b0, 5'd0, 8'd0);
            model_last[i] = 1;
        end
        step(); step(); step();

        // Reset values on both instances.
        for (int i = 0; i < 2; i++) begin
            check_idle(i, "rst");
            chk("rst_owner", 32'(owner_v[i]), 32'd1);
            chk("rst_done0", 32'(done0_v[i]), 32'd0);
            chk("rst_done1", 32'(done1_v[i]), 32'd0);
            chk("rst_rdata0", 32'(rdata0_v[i]), 32'd0);
            chk("rst_rdata1", 32'(rdata1_v[i]), 32'd0);
            chk("rst_ram_addr", 32'(ram_addr_v[i]), 32'd0);
            chk("rst_ram_data", 32'(ram_data_v[i]), 32'd0);
            chk("rst_wren", 32'(wren_v[i]), 32'd0);
        end
        reset = 1'b0;
        step();
        check_idle(0, "idle_no_req");

        // Basic write then read-back through the other port.
        run_txn(0, 0, 1'b1, 5'h03, 8'hA5, 1);
        run_txn(0, 1, 1'b0, 5'h03, 8'h00, 1);
        run_txn(0, 0, 1'b1, 5'h07, 8'h5A, 1);
        run_txn(0, 0, 1'b0, 5'h07, 8'h00, 1);

        // Both ports requesting continuously: grants must alternate.
        set_port(0, 0, 1'b1, 1'b1, 5'h0A, 8'h11);
        set_port(0, 1, 1'b1, 1'b1, 5'h0B, 8'h22);
        mem_model[0][5'h0A] = 8'h11;
        mem_model[0][5'h0B] = 8'h22;
        exp_p = 1 - model_last[0];
        for (int k = 0; k < 4; k++) begin
            exp_port_q.push_back(exp_p);
            exp_p = 1 - exp_p;
        end
        n = 0; cyc = 0;
        while (n < 4 && cyc < 40) begin
            step();
            cyc++;
            chk("no_done_collision", 32'(done0_v[0] & done1_v[0]), 32'd0);
            if (done0_v[0] || done1_v[0]) begin
                got = done1_v[0] ? 1 : 0;
                chk("fair_order", 32'(got), 32'(exp_port_q.pop_front()));
                chk("fair_owner", 32'(owner_v[0]), 32'(got));
                model_last[0] = got;
                n++;
                if (n == 4) begin
                    drop_req(0, 0);
                    drop_req(0, 1);
                end
            end
        end
        chk("fair_count", 32'(n), 32'd4);
        step();
        check_idle(0, "fair_end");
        run_txn(0, 1, 1'b0, 5'h0A, 8'h00, 1);
        run_txn(0, 0, 1'b0, 5'h0B, 8'h00, 1);

        // Random write/read-back pairs across ports.
        for (int k = 0; k < 3; k++) begin
            ra = 5'($urandom_range(0, 31));
            rd = 8'($urandom_range(0, 255));
            rp = int'($urandom_range(0, 1));
            run_txn(0, rp, 1'b1, ra, rd, 1);
            run_txn(0, 1 - rp, 1'b0, ra, 8'h00, 1);
        end

        // Three-cycle read latency instance, top address.
        run_txn(1, 0, 1'b1, 5'h1F, 8'h3C, 3);
        run_txn(1, 1, 1'b0, 5'h1F, 8'h00, 3);
        run_txn(1, 0, 1'b0, 5'h1F, 8'h00, 3);

        // req0 kept high through the IDLE cycle after done: second write starts.
        set_port(0, 0, 1'b1, 1'b1, 5'h10, 8'h77);
        mem_model[0][5'h10] = 8'h77;
        step();
        chk("ext_wren1", 32'(wren_v[0]), 32'd1);
        step();
        chk("ext_done1", 32'(done0_v[0]), 32'd1);
        step();
        chk("ext_idle", 32'(state_v[0]), 32'd0);
        chk("ext_idle_done", 32'(done0_v[0]), 32'd0);
        step();
        chk("ext_reissue", 32'(state_v[0]), 32'd1);
        chk("ext_wren2", 32'(wren_v[0]), 32'd1);
        drop_req(0, 0);
        step();
        chk("ext_done2", 32'(done0_v[0]), 32'd1);
        model_last[0] = 0;
        step();
        check_idle(0, "ext_end");

        // Make both read-data registers non-zero, then reset during a read's WAIT.
        run_txn(0, 1, 1'b0, 5'h03, 8'h00, 1);
        run_txn(0, 0, 1'b0, 5'h07, 8'h00, 1);
        set_port(0, 0, 1'b1, 1'b0, 5'h03, 8'h00);
        step();
        chk("rstw_issue", 32'(state_v[0]), 32'd1);
        step();
        chk("rstw_wait", 32'(state_v[0]), 32'd2);
        reset = 1'b1;
        drop_req(0, 0);
        step();
        check_idle(0, "rstw");
        chk("rstw_done0", 32'(done0_v[0]), 32'd0);
        chk("rstw_done1", 32'(done1_v[0]), 32'd0);
        chk("rstw_rdata0", 32'(rdata0_v[0]), 32'd0);
        chk("rstw_rdata1", 32'(rdata1_v[0]), 32'd0);
        chk("rstw_owner", 32'(owner_v[0]), 32'd1);
        reset = 1'b0;
        model_last[0] = 1;
        model_last[1] = 1;
        step();
        chk("rstw_no_late_done", 32'(done0_v[0]), 32'd0);
        check_idle(0, "rstw_after");
        run_txn(0, 0, 1'b0, 5'h03, 8'h00, 1);
        run_txn(0, 0, 1'b1, 5'h1E, 8'hC3, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
